tweet_buffer: RTL and testbench
===============================

# tweet_buffer

Parametrised serial message buffer. A UART receiver, a circular character store and a UART transmitter in one block. Characters arriving on `rx` are framed, checked and queued. A `play` pulse drains the queue in order onto `tx`. It sits between the board's serial input pin, the debounced write button and the serial output pin.

## Interface
Parameters:
- `CLK_DIV`, default 5208: sysclk cycles per bit. Legal range 4..65535.
- `DATA_W`, default 8: data bits per character. Legal range 5..9.
- `DEPTH_LOG2`, default 4: buffer depth is 2^DEPTH_LOG2 characters.

Ports (one clock; reset is synchronous and active-high):
- `sysclk`  in  1: system clock. Rising edge only.
- `reset`  in  1: synchronous, active-high. Clears all state.
- `rx`  in  1: asynchronous serial input. Idle high.
- `play`  in  1: single-cycle, already-debounced request to drain the buffer.
- `clear`  in  1: single-cycle request to empty the buffer.
- `tx`  out  1: serial output. Idle high.
- `busy`  out  1: high while a drain is in progress.
- `count`  out  DEPTH_LOG2+1: number of characters stored.
- `full`  out  1: `count` == 2^DEPTH_LOG2.
- `empty`  out  1: `count` == 0.
- `frame_err`  out  1: one-cycle pulse on a bad stop or parity bit.
- `overflow`  out  1: one-cycle pulse when a good character is dropped because the buffer is full.

## Operation
- Reset values: `tx`=1, `busy`=0, `count`=0, `empty`=1, `full`=0, `frame_err`=0, `overflow`=0. Both pointers and both FSMs return to IDLE.
- `rx` passes through a 2-flop synchroniser. All references to rx below mean the synchronised signal.
- RX FSM states: IDLE, START, DATA, PAR, STOP.
  - IDLE: a 1→0 transition moves to START and loads the bit counter.
  - START: sample at CLK_DIV/2 (integer division). If 1, treat as a glitch and return to IDLE with no pulse. If 0, go to DATA.
  - DATA: sample DATA_W bits every CLK_DIV cycles, LSB first.
  - PAR: entered only with `PARITY_EN`.
  - STOP: sample one bit. If 1 and parity is good, write the character. Otherwise pulse `frame_err`, discard the character, and return to IDLE.
- A write with `full`=1 is dropped and pulses `overflow`. `count` is unchanged.
- Buffer: wr_ptr and rd_ptr are DEPTH_LOG2 bits wide and wrap modulo depth. `count` is tracked separately.
- Drain:
  - `play` with `busy`=0 and `empty`=0 sets `busy`.
  - TX FSM states: IDLE, START, DATA, PAR, STOP. Frame is start bit 0, DATA_W bits LSB first, optional parity, stop bit 1.
  - Each character is popped (rd_ptr+1, `count`-1) on the cycle its START state begins.
  - After each STOP, if `empty`=0 the next character starts on the following cycle. Otherwise `busy` clears and TX returns to IDLE.
- `play` is ignored while `busy`=1 or while `empty`=1.
- A simultaneous write and pop both take effect; `count` is unchanged.
- Characters received during a drain are queued. If queued before the current STOP ends, they are transmitted in the same drain.
- `clear`:
  - Sets rd_ptr to wr_ptr and `count` to 0.
  - An in-flight TX character completes, then `busy` clears.
  - `clear` takes priority over a same-cycle write: that character is discarded.
- Parity is even; see Configuration.

## Timing
- TX frame length: (2 + DATA_W + P) × CLK_DIV cycles, where P=1 with `PARITY_EN` and 0 without.
- `play` accepted at cycle n: `tx` falls at cycle n+2 (one cycle for the buffer read, one cycle for the register). `busy` rises at n+1.
- RX: the stop bit is sampled CLK_DIV/2 + (1 + DATA_W + P) × CLK_DIV cycles after the synchronised falling edge. The write and the `frame_err`/`overflow` pulse occur on the next cycle. `count` updates the cycle after that.
- `full`, `empty` and `count` are registered and consistent with each other on every cycle.
- A `reset` asserted mid-frame forces `tx`=1 on the next cycle. Any partial RX character is discarded.

## Configuration
- `TWEET_BUFFER_PARITY_EN` defined:
  - One even-parity bit after the data bits in both directions.
  - An RX parity mismatch pulses `frame_err` and discards the character.
  - TX generates the parity bit as the XOR of the data bits.
- Not defined: no parity bit, P=0, PAR states absent.

## Test plan
- CLK_DIV=16, DATA_W=8, DEPTH_LOG2=2. Receive 0x48, 0x69. Pulse `play` → `tx` emits 0x48 then 0x69, each 160 cycles, back-to-back. `busy` falls after the second stop bit. `count` reaches 0, `empty`=1.
- Receive 5 characters into a 4-deep buffer → the 5th pulses `overflow` once and `count` stays 4. `play` replays only the first 4, in order, with pointers wrapping correctly.
- Receive 0x55 with the stop bit forced to 0 → `frame_err` pulses once and `count` stays 0. A 3-cycle low glitch on `rx` → no pulse and no write.
- Receive a character during a drain with `count`=1 → the new character is transmitted directly after the current one, and `count` never exceeds 1.
- Assert `reset` mid-TX and mid-RX → next cycle `tx`=1, `busy`=0, `count`=0. A later `play` is ignored.
- With `TWEET_BUFFER_PARITY_EN`: receive 0x07 with parity bit 1 → stored, and TX sends parity bit 1. Same character with parity bit 0 → `frame_err`.

Source files
------------

// File: rtl/tweet_buffer.sv
// rtl/tweet_buffer.sv - UART receiver, circular character store and UART transmitter
// Even parity in both directions is enabled by defining TWEET_BUFFER_PARITY_EN.
module tweet_buffer #(
    parameter int CLK_DIV    = 5208,
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  rx,
    input  logic                  play,
    input  logic                  clear,
    output logic                  tx,
    output logic                  busy,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  frame_err,
    output logic                  overflow
);
    localparam int                  DEPTH     = 1 << DEPTH_LOG2;
    localparam logic [15:0]         BIT_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0]         HALF_LAST = 16'(CLK_DIV / 2 - 1);
    localparam logic [3:0]          DATA_LAST = 4'(DATA_W - 1);
    localparam logic [DEPTH_LOG2:0] DEPTH_N   = (DEPTH_LOG2 + 1)'(DEPTH);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
`ifdef TWEET_BUFFER_PARITY_EN
    localparam logic [2:0] ST_PAR   = 3'd3;
`endif
    localparam logic [2:0] ST_STOP  = 3'd4;

    // rx_prev is the edge-detect stage behind the two synchroniser flops
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic [2:0]        rx_st;
    logic [15:0]       rx_cnt;
    logic [3:0]        rx_bit;
    logic [DATA_W-1:0] rx_shift;
    logic              wr_valid;
    logic [DATA_W-1:0] wr_data;
`ifdef TWEET_BUFFER_PARITY_EN
    logic              rx_pbit;
`endif

    always_ff @(posedge sysclk) begin
        if (reset) begin
            rx_st     <= ST_IDLE;
            rx_cnt    <= '0;
            rx_bit    <= '0;
            rx_shift  <= '0;
            wr_valid  <= 1'b0;
            wr_data   <= '0;
            frame_err <= 1'b0;
`ifdef TWEET_BUFFER_PARITY_EN
            rx_pbit   <= 1'b0;
`endif
        end else begin
            wr_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (rx_st)
                ST_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        rx_st  <= ST_START;
                        rx_cnt <= HALF_LAST;
                    end
                end
                ST_START: begin
                    if (rx_cnt == '0) begin
                        if (rx_sync) begin
                            rx_st <= ST_IDLE;
                        end else begin
                            rx_st  <= ST_DATA;
                            rx_cnt <= BIT_LAST;
                            rx_bit <= DATA_LAST;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_shift <= {rx_sync, rx_shift[DATA_W-1:1]};
                        rx_cnt   <= BIT_LAST;
                        if (rx_bit == '0) begin
`ifdef TWEET_BUFFER_PARITY_EN
                            rx_st <= ST_PAR;
`else
                            rx_st <= ST_STOP;
`endif
                        end else begin
                            rx_bit <= rx_bit - 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
`ifdef TWEET_BUFFER_PARITY_EN
                ST_PAR: begin
                    if (rx_cnt == '0) begin
                        rx_pbit <= rx_sync;
                        rx_cnt  <= BIT_LAST;
                        rx_st   <= ST_STOP;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (rx_cnt == '0) begin
                        rx_st <= ST_IDLE;
`ifdef TWEET_BUFFER_PARITY_EN
                        if (rx_sync && ((^rx_shift) == rx_pbit)) begin
`else
                        if (rx_sync) begin
`endif
                            wr_valid <= 1'b1;
                            wr_data  <= rx_shift;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: rx_st <= ST_IDLE;
            endcase
        end
    end

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count_next;
    logic                  wr_ok, pop, launch, launch_pending;
    logic [2:0]            tx_st;
    logic [15:0]           tx_cnt;

    // clear wins over a same-cycle write and cancels any pending launch
    assign wr_ok    = wr_valid && !full && !clear;
    assign overflow = wr_valid && full && !clear;
    assign launch   = !clear && !empty &&
                      ((tx_st == ST_IDLE && launch_pending) ||
                       (tx_st == ST_STOP && tx_cnt == '0));
    assign pop      = launch;

    always_comb begin
        count_next = count;
        if (clear) begin
            count_next = '0;
        end else if (wr_ok && !pop) begin
            count_next = count + 1'b1;
        end else if (pop && !wr_ok) begin
            count_next = count - 1'b1;
        end
    end

    always_ff @(posedge sysclk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (clear) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count_next;
            full  <= (count_next == DEPTH_N);
            empty <= (count_next == '0);
        end
    end

    logic [3:0]        tx_bit;
    logic [DATA_W-1:0] tx_shift;
`ifdef TWEET_BUFFER_PARITY_EN
    logic              tx_pbit;
`endif

    // launch covers both the first character after play and back-to-back follow-ons
    always_ff @(posedge sysclk) begin
        if (reset) begin
            tx_st          <= ST_IDLE;
            tx_cnt         <= '0;
            tx_bit         <= '0;
            tx_shift       <= '0;
            tx             <= 1'b1;
            busy           <= 1'b0;
            launch_pending <= 1'b0;
`ifdef TWEET_BUFFER_PARITY_EN
            tx_pbit        <= 1'b0;
`endif
        end else if (launch) begin
            tx_st          <= ST_START;
            tx             <= 1'b0;
            tx_cnt         <= BIT_LAST;
            tx_bit         <= DATA_LAST;
            tx_shift       <= mem[rd_ptr];
            launch_pending <= 1'b0;
`ifdef TWEET_BUFFER_PARITY_EN
            tx_pbit        <= ^mem[rd_ptr];
`endif
        end else begin
            case (tx_st)
                ST_IDLE: begin
                    if (launch_pending) begin
                        launch_pending <= 1'b0;
                        busy           <= 1'b0;
                    end else if (play && !busy && !empty && !clear) begin
                        busy           <= 1'b1;
                        launch_pending <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tx_cnt == '0) begin
                        tx       <= tx_shift[0];
                        tx_shift <= tx_shift >> 1;
                        tx_cnt   <= BIT_LAST;
                        tx_st    <= ST_DATA;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= BIT_LAST;
                        if (tx_bit == '0) begin
`ifdef TWEET_BUFFER_PARITY_EN
                            tx    <= tx_pbit;
                            tx_st <= ST_PAR;
`else
                            tx    <= 1'b1;
                            tx_st <= ST_STOP;
`endif
                        end else begin
                            tx       <= tx_shift[0];
                            tx_shift <= tx_shift >> 1;
                            tx_bit   <= tx_bit - 1'b1;
                        end
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
`ifdef TWEET_BUFFER_PARITY_EN
                ST_PAR: begin
                    if (tx_cnt == '0) begin
                        tx     <= 1'b1;
                        tx_cnt <= BIT_LAST;
                        tx_st  <= ST_STOP;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    if (tx_cnt == '0) begin
                        tx_st <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    tx_st <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_tweet_buffer.sv
// tb/tb_tweet_buffer.sv - randomized bench for tweet_buffer against a queue-based model
`timescale 1ns/1ps
module tb_tweet_buffer;
    localparam int CLK_DIV    = 16;
    localparam int DATA_W     = 8;
    localparam int DEPTH_LOG2 = 2;
    localparam int DEPTH      = 4;
`ifdef TWEET_BUFFER_PARITY_EN
    localparam int P = 1;
`else
    localparam int P = 0;
`endif
    localparam int FRAME = (2 + DATA_W + P) * CLK_DIV;

    logic sysclk = 1'b0, reset = 1'b1, rx = 1'b1, play = 1'b0, clear = 1'b0;
    logic tx, busy, full, empty, frame_err, overflow;
    logic [DEPTH_LOG2:0] count;

    tweet_buffer #(.CLK_DIV(CLK_DIV), .DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .sysclk(sysclk), .reset(reset), .rx(rx), .play(play), .clear(clear),
        .tx(tx), .busy(busy), .count(count), .full(full), .empty(empty),
        .frame_err(frame_err), .overflow(overflow)
    );

    always #5 sysclk = ~sysclk;

    int tests = 0, fails = 0, cyc = 0;
    int ferr_cnt = 0, ovf_cnt = 0, exp_ferr = 0, exp_ovf = 0;
    int incons = 0, stop_bad = 0, max_cnt = 0, busy_fall = 0;
    logic busy_q = 1'b0;
    logic [7:0] model_q[$];
    logic [7:0] dec_q[$];
    int start_q[$];
`ifdef TWEET_BUFFER_PARITY_EN
    logic last_par = 1'b0;
`endif

    always @(posedge sysclk) cyc <= cyc + 1;

    always @(negedge sysclk) begin
        if (frame_err === 1'b1) ferr_cnt++;
        if (overflow === 1'b1) ovf_cnt++;
        if (int'(count) > max_cnt) max_cnt = int'(count);
        if (!reset && (full !== (count == DEPTH) || empty !== (count == 0))) incons++;
        if (busy_q && !busy) busy_fall = cyc;
        busy_q = busy;
    end

    // serial decoder on tx: samples each bit in its middle
    initial begin : tx_mon
        logic [7:0] b;
        logic prev;
        prev = 1'b1;
        forever begin
            @(negedge sysclk);
            if (prev && tx === 1'b0) begin
                start_q.push_back(cyc);
                repeat (CLK_DIV / 2) @(negedge sysclk);
                b = '0;
                for (int i = 0; i < DATA_W; i++) begin
                    repeat (CLK_DIV) @(negedge sysclk);
                    b[i] = tx;
                end
`ifdef TWEET_BUFFER_PARITY_EN
                repeat (CLK_DIV) @(negedge sysclk);
                last_par = tx;
`endif
                repeat (CLK_DIV) @(negedge sysclk);
                if (tx !== 1'b1) stop_bad++;
                dec_q.push_back(b);
            end
            prev = tx;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] d, input logic bad_stop, input logic bad_par);
        rx = 1'b0;
        tick(CLK_DIV);
        for (int i = 0; i < DATA_W; i++) begin
            rx = d[i];
            tick(CLK_DIV);
        end
`ifdef TWEET_BUFFER_PARITY_EN
        rx = (^d) ^ bad_par;
        tick(CLK_DIV);
        rx = ~bad_stop;
`else
        rx = ~(bad_stop | bad_par);
`endif
        tick(CLK_DIV);
        rx = 1'b1;
    endtask

    task automatic host_rx(input logic [7:0] d);
        send_char(d, 1'b0, 1'b0);
        tick(CLK_DIV);
        if (model_q.size() == DEPTH) exp_ovf++;
        else model_q.push_back(d);
    endtask

    task automatic pulse_play();
        play = 1'b1;
        tick(1);
        play = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 20 * FRAME && busy; i++) tick(1);
        check(tag, busy, 0);
        tick(CLK_DIV);
    endtask

    task automatic compare_drain(input string tag);
        check({tag, "_nchars"}, dec_q.size(), model_q.size());
        for (int i = 0; i < model_q.size() && i < dec_q.size(); i++)
            check({tag, "_char"}, dec_q[i], model_q[i]);
        check({tag, "_count"}, count, 0);
        check({tag, "_empty"}, empty, 1);
        model_q.delete();
        dec_q.delete();
        start_q.delete();
    endtask

    initial begin : main
        logic [7:0] d1, d2;
        int n, f0;
        tick(3);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b0;
        tick(4);

        host_rx(8'h48);
        host_rx(8'h69);
        check("t1_count", count, 2);
        dec_q.delete();
        start_q.delete();
        pulse_play();
        check("t1_busy_n1", busy, 1);
        check("t1_tx_n1", tx, 1);
        tick(1);
        check("t1_tx_n2", tx, 0);
        wait_idle("t1_idle");
        check("t1_starts", start_q.size(), 2);
        if (start_q.size() >= 2) begin
            check("t1_gap", start_q[1] - start_q[0], FRAME);
            check("t1_busy_fall", busy_fall - start_q[1], FRAME);
        end
        compare_drain("t1");

        for (int i = 0; i < 5; i++) host_rx(8'($urandom));
        check("ovf_pulses", ovf_cnt, exp_ovf);
        check("ovf_count", count, DEPTH);
        check("ovf_full", full, 1);
        pulse_play();
        wait_idle("ovf_idle");
        compare_drain("ovf");

        for (int r = 0; r < 3; r++) begin
            n = $urandom_range(1, DEPTH);
            for (int k = 0; k < n; k++) host_rx(8'($urandom));
            check("rnd_count", count, n);
            pulse_play();
            wait_idle("rnd_idle");
            compare_drain("rnd");
        end

        send_char(8'h55, 1'b1, 1'b0);
        exp_ferr++;
        tick(CLK_DIV);
        check("ferr_pulses", ferr_cnt, exp_ferr);
        check("ferr_count", count, 0);
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(2 * CLK_DIV);
        check("glitch_ferr", ferr_cnt, exp_ferr);
        check("glitch_count", count, 0);

        d1 = 8'($urandom);
        d2 = 8'($urandom);
        host_rx(d1);
        max_cnt = 0;
        fork
            send_char(d2, 1'b0, 1'b0);
            begin
                tick(2 * CLK_DIV);
                pulse_play();
            end
        join
        model_q.push_back(d2);
        wait_idle("live_idle");
        check("live_max_count", max_cnt, 1);
        if (start_q.size() >= 2) check("live_gap", start_q[1] - start_q[0], FRAME);
        compare_drain("live");

        host_rx(8'($urandom));
        host_rx(8'($urandom));
        pulse_play();
        tick(50);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("clr_count", count, 0);
        check("clr_busy_held", busy, 1);
        wait_idle("clr_idle");
        while (model_q.size() > 1) void'(model_q.pop_back());
        compare_drain("clr");

`ifdef TWEET_BUFFER_PARITY_EN
        host_rx(8'h07);
        check("par_count", count, 1);
        pulse_play();
        wait_idle("par_idle");
        check("par_tx_bit", last_par, 1);
        compare_drain("par");
        send_char(8'h07, 1'b0, 1'b1);
        exp_ferr++;
        tick(CLK_DIV);
        check("par_ferr", ferr_cnt, exp_ferr);
        check("par_bad_count", count, 0);
`endif

        host_rx(8'($urandom));
        host_rx(8'($urandom));
        f0 = ferr_cnt;
        pulse_play();
        tick(20);
        rx = 1'b0;
        tick(30);
        reset = 1'b1;
        rx = 1'b1;
        tick(1);
        check("rst_mid_tx", tx, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_count", count, 0);
        reset = 1'b0;
        model_q.delete();
        tick(5);
        pulse_play();
        tick(2);
        check("rst_play_busy", busy, 0);
        check("rst_play_tx", tx, 1);
        tick(2 * FRAME);
        check("rst_no_ferr", ferr_cnt, f0);
        check("rst_no_write", count, 0);
        dec_q.delete();
        start_q.delete();

        check("ferr_total", ferr_cnt, exp_ferr);
        check("ovf_total", ovf_cnt, exp_ovf);
        check("stop_bits", stop_bad, 0);
        check("flag_consistency", incons, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
